// File: rtl/trigger_seq_ctrl.sv
// Trigger sequencer: snapshots per-pulse delay/width/count on an accepted match and plays
// out up to pNUM_TRIGGER_PULSES pulses on a registered trigger output.
module trigger_seq_ctrl #(
  parameter int unsigned pNUM_TRIGGER_PULSES = 8,
  parameter int unsigned pNUM_TRIGGER_WIDTH  = 4,
  parameter int unsigned pCNT_WIDTH          = 24
) (
  input  logic                                      fe_clk,
  input  logic                                      reset_n,
  input  logic                                      I_trigger_enable,
  input  logic                                      I_arm,
  input  logic                                      I_match,
  input  logic [pCNT_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_delay,
  input  logic [pCNT_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_width,
  input  logic [pNUM_TRIGGER_WIDTH-1:0]             I_num_triggers,
  output logic                                      O_trigger,
  output logic                                      O_busy,
  output logic                                      O_done,
  output logic [pNUM_TRIGGER_WIDTH-1:0]             O_pulse_index,
  output logic                                      O_match_ignored
);

  localparam int unsigned CfgW = pCNT_WIDTH * pNUM_TRIGGER_PULSES;

  typedef logic [pCNT_WIDTH-1:0]         cnt_t;
  typedef logic [pNUM_TRIGGER_WIDTH-1:0] idx_t;
  typedef enum logic [1:0] {StIdle, StDelay, StPulse, StDone} state_e;

  localparam idx_t MaxN = idx_t'(pNUM_TRIGGER_PULSES);

  state_e          state_q, state_d;
  cnt_t            cnt_q, cnt_d;
  idx_t            k_q, k_d, n_q, n_d, k_nxt, num_eff;
  logic [CfgW-1:0] dly_q, dly_d, wid_q, wid_d;
  logic            rearm_q, rearm_d;
  logic            trig_q, busy_q, done_q, ign_q, ign_d;
  logic            accept;
  cnt_t            dly0, wid0, wid_cur, dly_nxt, wid_nxt;

  // Counter load for a pulse: a width of 0 still produces one high cycle.
  function automatic cnt_t width_m1(input cnt_t w);
    return (w == '0) ? '0 : w - cnt_t'(1);
  endfunction

  assign k_nxt   = k_q + idx_t'(1);
  assign dly0    = I_trigger_delay[0 +: pCNT_WIDTH];
  assign wid0    = I_trigger_width[0 +: pCNT_WIDTH];
  assign wid_cur = wid_q[k_q * pCNT_WIDTH +: pCNT_WIDTH];
  assign dly_nxt = dly_q[k_nxt * pCNT_WIDTH +: pCNT_WIDTH];
  assign wid_nxt = wid_q[k_nxt * pCNT_WIDTH +: pCNT_WIDTH];
  assign accept  = I_match && I_arm && I_trigger_enable && !rearm_q;

  always_comb begin
    if (I_num_triggers == '0) begin
      num_eff = idx_t'(1);
    end else if (I_num_triggers > MaxN) begin
      num_eff = MaxN;
    end else begin
      num_eff = I_num_triggers;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    n_d     = n_q;
    dly_d   = dly_q;
    wid_d   = wid_q;
    rearm_d = I_arm ? rearm_q : 1'b0;
    ign_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          dly_d = I_trigger_delay;
          wid_d = I_trigger_width;
          n_d   = num_eff;
          k_d   = '0;
          // Zero delay goes straight to the pulse so the first high cycle is cycle 1.
          if (dly0 == '0) begin
            state_d = StPulse;
            cnt_d   = width_m1(wid0);
          end else begin
            state_d = StDelay;
            cnt_d   = dly0 - cnt_t'(1);
          end
        end else if (I_match) begin
          ign_d = 1'b1;
        end
      end
      StDelay: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = width_m1(wid_cur);
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StPulse: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_t'(1);
        end else if (k_nxt < n_q) begin
          k_d = k_nxt;
          if (dly_nxt == '0) begin
            cnt_d = width_m1(wid_nxt);
          end else begin
            state_d = StDelay;
            cnt_d   = dly_nxt - cnt_t'(1);
          end
        end else begin
          state_d = StDone;
          k_d     = '0;
          rearm_d = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && I_match) begin
      ign_d = 1'b1;
    end

    if ((state_q == StDelay || state_q == StPulse) && !I_trigger_enable) begin
      state_d = StIdle;
      cnt_d   = '0;
      k_d     = '0;
      rearm_d = 1'b1;
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      k_q     <= '0;
      n_q     <= '0;
      dly_q   <= '0;
      wid_q   <= '0;
      rearm_q <= 1'b0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      n_q     <= n_d;
      dly_q   <= dly_d;
      wid_q   <= wid_d;
      rearm_q <= rearm_d;
      trig_q  <= (state_d == StPulse);
      busy_q  <= (state_d == StDelay) || (state_d == StPulse);
      done_q  <= (state_d == StDone);
      ign_q   <= ign_d;
    end
  end

  assign O_trigger       = trig_q;
  assign O_busy          = busy_q;
  assign O_done          = done_q;
  assign O_pulse_index   = k_q;
  assign O_match_ignored = ign_q;

endmodule

// File: tb/tb_trigger_seq_ctrl.sv
// Scoreboard bench for trigger_seq_ctrl: expected per-cycle outputs are built from the
// pulse timing rules when a match is driven, then popped and compared every cycle.
module tb_trigger_seq_ctrl;

  localparam int unsigned NP = 8;
  localparam int unsigned NW = 4;
  localparam int unsigned CW = 24;

  logic              fe_clk;
  logic              reset_n;
  logic              I_trigger_enable;
  logic              I_arm;
  logic              I_match;
  logic [CW*NP-1:0]  I_trigger_delay;
  logic [CW*NP-1:0]  I_trigger_width;
  logic [NW-1:0]     I_num_triggers;
  logic              O_trigger;
  logic              O_busy;
  logic              O_done;
  logic [NW-1:0]     O_pulse_index;
  logic              O_match_ignored;

  typedef struct packed {
    logic          trig;
    logic          busy;
    logic          done;
    logic          ign;
    logic [NW-1:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  trigger_seq_ctrl #(
    .pNUM_TRIGGER_PULSES(NP),
    .pNUM_TRIGGER_WIDTH (NW),
    .pCNT_WIDTH         (CW)
  ) dut (
    .fe_clk          (fe_clk),
    .reset_n         (reset_n),
    .I_trigger_enable(I_trigger_enable),
    .I_arm           (I_arm),
    .I_match         (I_match),
    .I_trigger_delay (I_trigger_delay),
    .I_trigger_width (I_trigger_width),
    .I_num_triggers  (I_num_triggers),
    .O_trigger       (O_trigger),
    .O_busy          (O_busy),
    .O_done          (O_done),
    .O_pulse_index   (O_pulse_index),
    .O_match_ignored (O_match_ignored)
  );

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Pop one expected entry and compare against the outputs visible now.
  task automatic sb_compare(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check_eq({tag, "_trig"}, 32'(O_trigger), 32'(e.trig));
    check_eq({tag, "_busy"}, 32'(O_busy), 32'(e.busy));
    check_eq({tag, "_done"}, 32'(O_done), 32'(e.done));
    check_eq({tag, "_ign"}, 32'(O_match_ignored), 32'(e.ign));
    check_eq({tag, "_idx"}, 32'(O_pulse_index), 32'(e.idx));
  endtask

  function automatic logic [CW*NP-1:0] pk(input int v0, input int v1, input int v2,
                                          input int v3, input int v4, input int v5,
                                          input int v6, input int v7);
    return {CW'(v7), CW'(v6), CW'(v5), CW'(v4), CW'(v3), CW'(v2), CW'(v1), CW'(v0)};
  endfunction

  // Drive a match on cycle 0 and score cycles 1..done+1. extra_match>0 adds a second match
  // on that cycle; abort_at>=0 drops the enable on that cycle.
  task automatic run_seq(input string tag, input logic [CW*NP-1:0] dly,
                         input logic [CW*NP-1:0] wid, input int num,
                         input int extra_match, input int abort_at);
    exp_t tr[200];
    int   n, t, start, w, d, last;
    for (int c = 0; c < 200; c++) tr[c] = '0;
    n = (num == 0) ? 1 : (num > int'(NP)) ? int'(NP) : num;
    t = 0;
    for (int k = 0; k < n; k++) begin
      d = int'(dly[k*CW +: CW]);
      w = int'(wid[k*CW +: CW]);
      if (w == 0) w = 1;
      start = t + 1 + d;
      for (int c = t + 1; c < start; c++) begin
        tr[c].busy = 1'b1;
        tr[c].idx  = NW'(k);
      end
      for (int c = start; c < start + w; c++) begin
        tr[c].trig = 1'b1;
        tr[c].busy = 1'b1;
        tr[c].idx  = NW'(k);
      end
      t = start + w - 1;
    end
    last = t + 1;
    tr[last].done = 1'b1;
    if (abort_at >= 0) begin
      for (int c = abort_at + 1; c <= last; c++) tr[c] = '0;
      last = abort_at + 1;
    end
    if (extra_match > 0) tr[extra_match + 1].ign = 1'b1;
    for (int c = 1; c <= last + 1; c++) exp_q.push_back(tr[c]);

    I_trigger_delay  = dly;
    I_trigger_width  = wid;
    I_num_triggers   = NW'(num);
    I_arm            = 1'b1;
    I_trigger_enable = 1'b1;
    I_match          = 1'b1;
    for (int c = 1; c <= last + 1; c++) begin
      @(negedge fe_clk);
      sb_compare(tag);
      I_match          = (c == extra_match);
      I_trigger_enable = !(abort_at >= 0 && c >= abort_at);
      // Config churn mid-run must not disturb the snapshot.
      if (c == 2) begin
        I_trigger_delay = ~dly;
        I_trigger_width = ~wid;
        I_num_triggers  = ~NW'(num);
      end
    end
    I_match          = 1'b0;
    I_trigger_enable = 1'b1;
  endtask

  task automatic expect_refused(input string tag);
    I_match = 1'b1;
    exp_q.push_back('{trig: 1'b0, busy: 1'b0, done: 1'b0, ign: 1'b1, idx: '0});
    @(negedge fe_clk);
    sb_compare(tag);
    I_match = 1'b0;
    exp_q.push_back('0);
    @(negedge fe_clk);
    sb_compare(tag);
  endtask

  task automatic rearm();
    I_arm = 1'b0;
    @(negedge fe_clk);
    I_arm = 1'b1;
    @(negedge fe_clk);
  endtask

  initial begin
    n_cmp            = 0;
    n_bad            = 0;
    reset_n          = 1'b0;
    I_trigger_enable = 1'b1;
    I_arm            = 1'b1;
    I_match          = 1'b0;
    I_trigger_delay  = '0;
    I_trigger_width  = '0;
    I_num_triggers   = '0;
    #12;
    check_eq("rst_trig", 32'(O_trigger), 32'd0);
    check_eq("rst_busy", 32'(O_busy), 32'd0);
    @(negedge fe_clk);
    reset_n = 1'b1;
    exp_q.push_back('0);
    @(negedge fe_clk);
    sb_compare("idle");

    // Single pulse; second match lands on the O_done cycle.
    run_seq("t1", pk(3, 0, 0, 0, 0, 0, 0, 0), pk(2, 0, 0, 0, 0, 0, 0, 0), 1, 6, -1);
    expect_refused("norearm");
    rearm();

    // Three pulses with a merged zero-delay pulse; match while busy.
    run_seq("t2", pk(2, 0, 5, 0, 0, 0, 0, 0), pk(1, 2, 1, 0, 0, 0, 0, 0), 3, 4, -1);
    rearm();

    run_seq("t3a", pk(0, 9, 9, 9, 9, 9, 9, 9), pk(0, 9, 9, 9, 9, 9, 9, 9), 0, -1, -1);
    rearm();
    run_seq("t3b", pk(0, 1, 0, 2, 0, 1, 0, 3), pk(1, 0, 2, 1, 3, 1, 1, 2), 15, -1, -1);
    rearm();

    I_arm = 1'b0;
    expect_refused("arm_low");
    I_arm = 1'b1;
    @(negedge fe_clk);

    // Abort during pulse 1 of 3; then no retrigger until rearmed.
    run_seq("t5", pk(1, 1, 1, 0, 0, 0, 0, 0), pk(2, 3, 2, 0, 0, 0, 0, 0), 3, -1, 6);
    expect_refused("abort_norearm");
    rearm();
    run_seq("t5b", pk(4, 0, 0, 0, 0, 0, 0, 0), pk(3, 0, 0, 0, 0, 0, 0, 0), 1, -1, -1);
    rearm();

    // Async reset in the middle of a long pulse.
    I_trigger_delay = pk(1, 0, 0, 0, 0, 0, 0, 0);
    I_trigger_width = pk(10, 0, 0, 0, 0, 0, 0, 0);
    I_num_triggers  = NW'(1);
    I_match         = 1'b1;
    @(negedge fe_clk);
    I_match = 1'b0;
    @(negedge fe_clk);
    @(negedge fe_clk);
    check_eq("pre_rst_trig", 32'(O_trigger), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_trig", 32'(O_trigger), 32'd0);
    check_eq("async_rst_busy", 32'(O_busy), 32'd0);
    @(negedge fe_clk);
    reset_n = 1'b1;
    exp_q.push_back('0);
    @(negedge fe_clk);
    sb_compare("post_rst");
    run_seq("t6", pk(2, 0, 0, 0, 0, 0, 0, 0), pk(1, 0, 0, 0, 0, 0, 0, 0), 1, -1, -1);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
